// File: rtl/cavlc_bit_packer.sv
// CAVLC bit packer: concatenates variable-length code fragments MSB-first
// into fixed-width, left-aligned output words, with an end-of-block flush
// that emits a zero-padded final word and a completion pulse.
module cavlc_bit_packer #(
    parameter int CODE_W = 19,
    parameter int OUT_W  = 32,
    parameter int CNT_W  = 32,
    localparam int LEN_W = $clog2(CODE_W + 1),
    localparam int OB_W  = $clog2(OUT_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code_bit,
    input  logic [LEN_W-1:0]  code_len,
    input  logic              in_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [OB_W-1:0]   out_bits,
    output logic              out_last,
    output logic              flush_done,
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam int BUF_W  = OUT_W + CODE_W - 1;
    localparam int FILL_W = $clog2(BUF_W + 1);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               alive_q;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [OB_W-1:0]    out_bits_q, out_bits_d;
    logic               out_last_q, out_last_d;
    logic               flush_done_q, flush_done_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

    logic [LEN_W-1:0]   len_eff;
    logic [CODE_W-1:0]  code_masked;
    logic [FILL_W-1:0]  shamt;
    logic [BUF_W-1:0]   appended;
    logic               accept;
    logic               out_hs;
    logic               word_full;

    // Ready depends only on registered state; alive_q holds it low through reset.
    assign in_ready = alive_q & (state_q == RUN) & (fill_q < FILL_W'(OUT_W));

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_bits   = out_bits_q;
    assign out_last   = out_last_q;
    assign flush_done = flush_done_q;
    assign bit_cnt    = bit_cnt_q;

    // Clamp the length, drop bits at or above it, and place them just below the valid bits.
    always_comb begin
        if (code_len > LEN_W'(CODE_W)) begin
            len_eff = LEN_W'(CODE_W);
        end else begin
            len_eff = code_len;
        end
        code_masked = {CODE_W{1'b0}};
        for (int i = 0; i < CODE_W; i++) begin
            code_masked[i] = (i < int'(len_eff)) ? code_bit[i] : 1'b0;
        end
        shamt    = FILL_W'(BUF_W) - fill_q - FILL_W'(len_eff);
        appended = buf_q | (BUF_W'(code_masked) << shamt);
    end

    // Next-state logic: buffer, fill, counter and RUN/FLUSH transitions.
    always_comb begin
        accept       = in_valid & in_ready;
        out_hs       = out_valid_q & out_ready;
        state_d      = state_q;
        buf_d        = buf_q;
        fill_d       = fill_q;
        bit_cnt_d    = bit_cnt_q;
        flush_done_d = 1'b0;
        if (out_hs) begin
            if (out_last_q) begin
                buf_d        = {BUF_W{1'b0}};
                fill_d       = {FILL_W{1'b0}};
                bit_cnt_d    = {CNT_W{1'b0}};
                flush_done_d = 1'b1;
                state_d      = RUN;
            end else begin
                buf_d  = buf_q << OUT_W;
                fill_d = fill_q - FILL_W'(OUT_W);
            end
        end else if (accept) begin
            buf_d     = appended;
            fill_d    = fill_q + FILL_W'(len_eff);
            bit_cnt_d = bit_cnt_q + CNT_W'(len_eff);
            if (in_flush) begin
                if (fill_d == {FILL_W{1'b0}}) begin
                    // Nothing buffered: the flush completes without any output word.
                    flush_done_d = 1'b1;
                    bit_cnt_d    = {CNT_W{1'b0}};
                    state_d      = RUN;
                end else begin
                    state_d = FLUSH;
                end
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Output word decode from the next buffer state so outputs can be registered.
    always_comb begin
        word_full   = (fill_d >= FILL_W'(OUT_W));
        out_valid_d = word_full | ((state_d == FLUSH) & (fill_d != {FILL_W{1'b0}}));
        out_last_d  = out_valid_d & (state_d == FLUSH) & (fill_d <= FILL_W'(OUT_W));
        if (out_valid_d) begin
            out_data_d = buf_d[BUF_W-1 -: OUT_W];
            if (word_full) begin
                out_bits_d = OB_W'(OUT_W);
            end else begin
                out_bits_d = OB_W'(fill_d);
            end
        end else begin
            out_data_d = {OUT_W{1'b0}};
            out_bits_d = {OB_W{1'b0}};
        end
    end

    // State and output registers; reset discards everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            buf_q        <= {BUF_W{1'b0}};
            fill_q       <= {FILL_W{1'b0}};
            alive_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= {OUT_W{1'b0}};
            out_bits_q   <= {OB_W{1'b0}};
            out_last_q   <= 1'b0;
            flush_done_q <= 1'b0;
            bit_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            fill_q       <= fill_d;
            alive_q      <= 1'b1;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_bits_q   <= out_bits_d;
            out_last_q   <= out_last_d;
            flush_done_q <= flush_done_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

endmodule
